// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
// Holds the next-PC source encoding, the word increment and a generic
// sign-extension helper used for branch/jump offsets.
package pc_pkg;

  // Next-PC source, listed from lowest to highest priority except RET (top).
  typedef enum logic [2:0] {
    SEQ = 3'd0,
    BR  = 3'd1,
    JMP = 3'd2,
    JR  = 3'd3,
    RET = 3'd4
  } pc_sel_e;

  // Addressing is in words, so the sequential step is one.
  localparam int unsigned PC_INC = 32'd1;

  // Sign-extend the low 'width' bits of 'val' to 64 bits. Callers truncate
  // the result to their address width, so XLEN must not exceed 64.
  function automatic logic [63:0] sext(input logic [63:0] val, input int unsigned width);
    logic [63:0] res;
    logic [5:0]  msb;
    logic        sign;
    msb  = 6'(width - 32'd1);
    sign = val[msb];
    res  = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(width)) begin
        res[i] = val[i];
      end else begin
        res[i] = sign;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. top_q points at the most recent entry;
// a push onto a full stack advances the pointer and overwrites the oldest
// entry. All request inputs arrive already qualified by the stall enable.
// RAS_DEPTH is expected to be a power of two and at least 2.
module return_addr_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            ret_i,
  input  logic            repl_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic             empty_s, full_s;

  assign empty_s     = (count_q == {CNT_W{1'b0}});
  assign full_s      = (count_q == CNT_MAX);
  assign empty_o     = empty_s;
  assign full_o      = full_s;
  assign top_o       = mem_q[top_q];
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  // Next pointer/count, entry write and event pulses; flush beats ret beats push.
  always_comb begin
    top_d    = top_q;
    count_d  = count_q;
    we_s     = 1'b0;
    wr_ptr_s = top_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (flush_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (ret_i) begin
      if (empty_s) begin
        unf_d = 1'b1;
      end else if (repl_i) begin
        // ret together with call: consume the top and push in one step.
        we_s     = 1'b1;
        wr_ptr_s = top_q;
      end else begin
        top_d   = top_q - PTR_W'(1'b1);
        count_d = count_q - CNT_W'(1'b1);
      end
    end else if (push_i) begin
      top_d    = top_q + PTR_W'(1'b1);
      we_s     = 1'b1;
      wr_ptr_s = top_q + PTR_W'(1'b1);
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1'b1);
      end
    end else begin
      top_d = top_q;
    end
  end

  // Pointer, occupancy and one-cycle event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q   <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; contents are meaningless while not counted, so no reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wr_ptr_s] <= wdata_i;
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program-counter unit. Selects the next word address from
// sequential, branch, jump/call, register jump and return sources and
// registers it on the rising clock edge when pc_write is high.
// Define PC_RAS_EN to build the return-address stack; without it, ret
// behaves exactly like jr and the stack status outputs are tied off.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     OFF_W     = 14,
  parameter int unsigned     RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             branch,
  input  logic             jump,
  input  logic             call,
  input  logic             jr,
  input  logic             ret,
  input  logic             ras_flush,
  input  logic [OFF_W-1:0] offset,
  input  logic [OFF_W-1:0] target,
  input  logic [XLEN-1:0]  jump_addr,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  return_addr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] seq_pc_s, br_pc_s, jmp_pc_s, next_pc_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_hit_s;
  pc_sel_e         sel_s;

  assign seq_pc_s    = pc_q + XLEN'(PC_INC);
  assign br_pc_s     = pc_q + XLEN'(sext(64'(offset), OFF_W));
  assign jmp_pc_s    = pc_q + XLEN'(sext(64'(target), OFF_W));
  assign pc_out      = pc_q;
  assign return_addr = seq_pc_s;

`ifdef PC_RAS_EN
  logic ras_push_s, ras_ret_s, ras_repl_s, ras_flush_s;
  logic ras_empty_s;

  // Stack requests only take effect on non-stalled cycles.
  assign ras_push_s  = pc_write & jump & call & ~ret;
  assign ras_ret_s   = pc_write & ret;
  assign ras_repl_s  = pc_write & ret & jump & call;
  assign ras_flush_s = pc_write & ras_flush;
  assign ras_hit_s   = ~ras_empty_s;
  assign ras_empty   = ras_empty_s;

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push_s),
    .ret_i       (ras_ret_s),
    .repl_i      (ras_repl_s),
    .flush_i     (ras_flush_s),
    .wdata_i     (seq_pc_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s),
    .full_o      (ras_full),
    .overflow_o  (ras_overflow),
    .underflow_o (ras_underflow)
  );
`else
  logic unused_ras_s;

  assign ras_hit_s     = 1'b0;
  assign ras_top_s     = {XLEN{1'b0}};
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
  assign unused_ras_s  = ^{call, ras_flush};
`endif

  // Source priority: ret > jr > jump > branch > sequential.
  always_comb begin
    if (ret) begin
      sel_s = RET;
    end else if (jr) begin
      sel_s = JR;
    end else if (jump) begin
      sel_s = JMP;
    end else if (branch) begin
      sel_s = BR;
    end else begin
      sel_s = SEQ;
    end
  end

  // Next-PC mux; a stall holds the current PC.
  always_comb begin
    next_pc_s = seq_pc_s;
    case (sel_s)
      SEQ:     next_pc_s = seq_pc_s;
      BR:      next_pc_s = br_pc_s;
      JMP:     next_pc_s = jmp_pc_s;
      JR:      next_pc_s = jump_addr;
      RET:     next_pc_s = ras_hit_s ? ras_top_s : jump_addr;
      default: next_pc_s = seq_pc_s;
    endcase
    if (pc_write) begin
      pc_d = next_pc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed, table-driven bench for pc_unit_ras. The common table covers
// PC selection and stalls; the stack sequences follow the PC_RAS_EN build.
module tb_pc_unit_ras;

  typedef struct {
    logic        pw;
    logic        br;
    logic        jmp;
    logic        cl;
    logic        jr;
    logic        rt;
    logic        fl;
    logic [13:0] off;
    logic [13:0] tgt;
    logic [31:0] ja;
    logic [31:0] epc;
    logic        eem;
    logic        efu;
    logic        eov;
    logic        eun;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        pc_write, branch, jump, call, jr, ret, ras_flush;
  logic [13:0] offset, target;
  logic [31:0] jump_addr;
  logic [31:0] pc_out, return_addr;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int checks   = 0;
  int failures = 0;

  localparam int NV = 15;
  vec_t tbl [NV];

  pc_unit_ras #(
    .XLEN      (32),
    .OFF_W     (14),
    .RAS_DEPTH (8),
    .RESET_PC  (32'h100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .branch        (branch),
    .jump          (jump),
    .call          (call),
    .jr            (jr),
    .ret           (ret),
    .ras_flush     (ras_flush),
    .offset        (offset),
    .target        (target),
    .jump_addr     (jump_addr),
    .pc_out        (pc_out),
    .return_addr   (return_addr),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pw, input logic br, input logic jmp, input logic cl,
                              input logic jrr, input logic rt, input logic fl,
                              input logic [13:0] off, input logic [13:0] tgt, input logic [31:0] ja,
                              input logic [31:0] epc, input logic eem, input logic efu,
                              input logic eov, input logic eun);
    vec_t v;
    v.pw = pw; v.br = br; v.jmp = jmp; v.cl = cl; v.jr = jrr; v.rt = rt; v.fl = fl;
    v.off = off; v.tgt = tgt; v.ja = ja;
    v.epc = epc; v.eem = eem; v.efu = efu; v.eov = eov; v.eun = eun;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    pc_write = v.pw; branch = v.br; jump = v.jmp; call = v.cl;
    jr = v.jr; ret = v.rt; ras_flush = v.fl;
    offset = v.off; target = v.tgt; jump_addr = v.ja;
    @(posedge clk);
    #1;
    chk({tag, ".pc"}, pc_out, v.epc);
    chk({tag, ".ra"}, return_addr, v.epc + 32'd1);
    chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, v.eem});
    chk({tag, ".full"}, {31'd0, ras_full}, {31'd0, v.efu});
    chk({tag, ".ovf"}, {31'd0, ras_overflow}, {31'd0, v.eov});
    chk({tag, ".unf"}, {31'd0, ras_underflow}, {31'd0, v.eun});
  endtask

  initial begin
    //              pw br jp cl jr rt fl off       tgt       ja            exp pc        em fu ov un
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 32'h0,        32'h101,      1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 32'h0,        32'h102,      1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 32'h0,        32'h103,      1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 0, 0, 14'h0000, 14'h0000, 32'h10,       32'h10,       1, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0, 14'h3FFE, 14'h0000, 32'h0,        32'h0E,       1, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 0, 1, 0, 0, 14'h0007, 14'h0005, 32'h40,       32'h40,       1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0, 0, 0, 14'h0000, 14'h0010, 32'h0,        32'h40,       1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 1, 0, 0, 0, 14'h0000, 14'h0010, 32'h0,        32'h40,       1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 1, 0, 0, 0, 14'h0000, 14'h0010, 32'h0,        32'h40,       1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 0, 0, 0, 14'h0000, 14'h0010, 32'h0,        32'h40,       1, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 14'h0005, 14'h0000, 32'h0,        32'h45,       1, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 0, 0, 0, 0, 14'h0000, 14'h2000, 32'h0,        32'hFFFFE045, 1, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 0, 14'h0001, 14'h0000, 32'h0,        32'hFFFFE046, 1, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 1, 0, 0, 14'h0000, 14'h0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 32'h0,        32'h0,        1, 0, 0, 0);

    reset = 1'b1;
    pc_write = 1'b0; branch = 1'b0; jump = 1'b0; call = 1'b0;
    jr = 1'b0; ret = 1'b0; ras_flush = 1'b0;
    offset = 14'h0; target = 14'h0; jump_addr = 32'h0;
    #12;
    chk("reset.pc", pc_out, 32'h100);
    chk("reset.empty", {31'd0, ras_empty}, 32'd1);
    chk("reset.full", {31'd0, ras_full}, 32'd0);
    chk("reset.ovf", {31'd0, ras_overflow}, 32'd0);
    chk("reset.unf", {31'd0, ras_underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

`ifdef PC_RAS_EN
    // Two nested calls, two returns, then a return on an empty stack.
    apply(mk(1, 0, 0, 0, 1, 0, 0, 14'h0, 14'h0,  32'h20, 32'h20, 1, 0, 0, 0), "nest.jr");
    apply(mk(1, 0, 1, 1, 0, 0, 0, 14'h0, 14'h10, 32'h0,  32'h30, 0, 0, 0, 0), "nest.call1");
    apply(mk(1, 0, 1, 1, 0, 0, 0, 14'h0, 14'h10, 32'h0,  32'h40, 0, 0, 0, 0), "nest.call2");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h0,  32'h31, 0, 0, 0, 0), "nest.ret1");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h0,  32'h21, 1, 0, 0, 0), "nest.ret2");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h77, 32'h77, 1, 0, 0, 1), "nest.ret3");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 14'h0, 14'h0,  32'h0,  32'h78, 1, 0, 0, 0), "nest.seq");

    // Stalled ret/flush/call must leave the stack alone.
    apply(mk(1, 0, 1, 1, 0, 0, 0, 14'h0, 14'h8,  32'h0,  32'h80, 0, 0, 0, 0), "stall.call");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h55, 32'h80, 0, 0, 0, 0), "stall.ret");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 14'h0, 14'h0,  32'h0,  32'h80, 0, 0, 0, 0), "stall.flush");
    apply(mk(0, 0, 1, 1, 0, 0, 0, 14'h0, 14'h8,  32'h0,  32'h80, 0, 0, 0, 0), "stall.call2");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h55, 32'h79, 1, 0, 0, 0), "stall.ret_after");

    // Nine calls into an 8-deep stack, then eight returns newest first.
    apply(mk(1, 0, 0, 0, 1, 0, 0, 14'h0, 14'h0, 32'h200, 32'h200, 1, 0, 0, 0), "ovf.jr");
    for (int i = 0; i < 9; i++) begin
      apply(mk(1, 0, 1, 1, 0, 0, 0, 14'h0, 14'h1, 32'h0, 32'h201 + 32'(i),
               1'b0, (i >= 7), (i == 8), 1'b0), $sformatf("ovf.call%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0, 32'h0, 32'h209 - 32'(i),
               (i == 7), 1'b0, 1'b0, 1'b0), $sformatf("ovf.ret%0d", i));
    end

    // ret together with call replaces the top entry; then flush.
    apply(mk(1, 0, 0, 0, 1, 0, 0, 14'h0, 14'h0,  32'h20, 32'h20, 1, 0, 0, 0), "rc.jr");
    apply(mk(1, 0, 1, 1, 0, 0, 0, 14'h0, 14'h30, 32'h0,  32'h50, 0, 0, 0, 0), "rc.call");
    apply(mk(1, 0, 1, 1, 0, 1, 0, 14'h0, 14'h5,  32'h99, 32'h21, 0, 0, 0, 0), "rc.retcall");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h99, 32'h51, 1, 0, 0, 0), "rc.ret");
    apply(mk(1, 0, 1, 1, 0, 0, 0, 14'h0, 14'h1,  32'h0,  32'h52, 0, 0, 0, 0), "fl.call");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 14'h0, 14'h0,  32'h0,  32'h52, 0, 0, 0, 0), "fl.stalled");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 14'h0, 14'h0,  32'h0,  32'h53, 1, 0, 0, 0), "fl.flush");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h66, 32'h66, 1, 0, 0, 1), "fl.ret");
`else
    // Without the stack, ret follows jump_addr and call does nothing extra.
    apply(mk(1, 0, 0, 0, 1, 0, 0, 14'h0, 14'h0,  32'h50, 32'h50, 1, 0, 0, 0), "nr.jr");
    apply(mk(1, 0, 1, 1, 0, 1, 0, 14'h0, 14'h10, 32'h77, 32'h77, 1, 0, 0, 0), "nr.retcall");
    apply(mk(1, 0, 1, 1, 0, 0, 0, 14'h0, 14'h10, 32'h0,  32'h87, 1, 0, 0, 0), "nr.call");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h99, 32'h99, 1, 0, 0, 0), "nr.ret");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 14'h0, 14'h0,  32'h11, 32'h99, 1, 0, 0, 0), "nr.stall");
`endif

    // Reset asserted mid-cycle while pc_write is high acts at once.
    pc_write = 1'b1; branch = 1'b0; jump = 1'b0; call = 1'b0;
    jr = 1'b0; ret = 1'b0; ras_flush = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("areset.pc", pc_out, 32'h100);
    chk("areset.empty", {31'd0, ras_empty}, 32'd1);
    chk("areset.unf", {31'd0, ras_underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 14'h0, 14'h0, 32'h0, 32'h101, 1, 0, 0, 0), "areset.seq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
